// File: rtl/instr_encoder.sv
// MIPS-style instruction encoder with a 2-entry output FIFO and per-word byte addresses.
// Optional macro INSTR_ENCODER_ERRCNT_EN enables the saturating illegal-mnemonic counter.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic [31:0] addr,
    output logic        err,
    output logic [7:0]  err_count
);

    localparam logic [3:0] MnLw    = 4'd0;
    localparam logic [3:0] MnSw    = 4'd1;
    localparam logic [3:0] MnJ     = 4'd2;
    localparam logic [3:0] MnJal   = 4'd3;
    localparam logic [3:0] MnBeq   = 4'd4;
    localparam logic [3:0] MnBne   = 4'd5;
    localparam logic [3:0] MnXori  = 4'd6;
    localparam logic [3:0] MnAddi  = 4'd7;
    localparam logic [3:0] MnAddiu = 4'd8;
    localparam logic [3:0] MnJr    = 4'd9;
    localparam logic [3:0] MnAdd   = 4'd10;
    localparam logic [3:0] MnSub   = 4'd11;
    localparam logic [3:0] MnSlt   = 4'd12;

    logic        legal;
    logic [31:0] word;

    always_comb begin
        legal = 1'b1;
        word  = '0;
        case (mnem)
            MnLw:    word = {6'b100011, rs, rt, imm};
            MnSw:    word = {6'b101011, rs, rt, imm};
            MnBeq:   word = {6'b000100, rs, rt, imm};
            MnBne:   word = {6'b000101, rs, rt, imm};
            MnXori:  word = {6'b001110, rs, rt, imm};
            MnAddi:  word = {6'b001000, rs, rt, imm};
            MnAddiu: word = {6'b001001, rs, rt, imm};
            MnJ:     word = {6'b000010, target};
            MnJal:   word = {6'b000011, target};
            MnJr:    word = {6'b000000, rs, 5'd0, 5'd0, 5'd0, 6'b001000};
            MnAdd:   word = {6'b000000, rs, rt, rd, 5'd0, 6'b100000};
            MnSub:   word = {6'b000000, rs, rt, rd, 5'd0, 6'b100010};
            MnSlt:   word = {6'b000000, rs, rt, rd, 5'd0, 6'b101010};
            default: legal = 1'b0;
        endcase
    end

    logic [31:0] mem_instr_q [2];
    logic [31:0] mem_instr_d [2];
    logic [31:0] mem_addr_q  [2];
    logic [31:0] mem_addr_d  [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] next_addr_q, next_addr_d;
    logic        err_q, err_d;
    logic        accept, push, pop;

    // Full is judged from registered occupancy so a same-cycle pop never re-opens the input.
    assign in_ready  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign accept    = in_valid & in_ready;
    assign push      = accept & legal;
    assign pop       = out_valid & out_ready;
    assign instr     = mem_instr_q[rd_ptr_q];
    assign addr      = mem_addr_q[rd_ptr_q];
    assign err       = err_q;

    always_comb begin
        mem_instr_d = mem_instr_q;
        mem_addr_d  = mem_addr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        next_addr_d = next_addr_q;
        if (push) begin
            mem_instr_d[wr_ptr_q] = word;
            mem_addr_d[wr_ptr_q]  = next_addr_q;
            wr_ptr_d              = ~wr_ptr_q;
            next_addr_d           = next_addr_q + 32'd4;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
        err_d = accept & ~legal;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_instr_q <= '{default: '0};
            mem_addr_q  <= '{default: '0};
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= 2'd0;
            next_addr_q <= BASE_ADDR;
            err_q       <= 1'b0;
        end else begin
            mem_instr_q <= mem_instr_d;
            mem_addr_q  <= mem_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            next_addr_q <= next_addr_d;
            err_q       <= err_d;
        end
    end

`ifdef INSTR_ENCODER_ERRCNT_EN
    logic [7:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (err_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_count_q <= 8'h00;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`else
    assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors plus random traffic against a queue model.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  mnem;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr, addr;
    logic        err;
    logic [7:0]  err_count;

    logic        in_ready2, out_valid2, err2;
    logic [31:0] instr2, addr2;
    logic [7:0]  err_count2;

    always #5 clk = ~clk;

    instr_encoder dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .mnem(mnem),
        .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target), .out_valid(out_valid),
        .out_ready(out_ready), .instr(instr), .addr(addr), .err(err), .err_count(err_count)
    );

    // Second instance near the top of the address space to exercise the wrap.
    instr_encoder #(.BASE_ADDR(32'hFFFF_FFF8)) dut_hi (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2), .mnem(mnem),
        .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target), .out_valid(out_valid2),
        .out_ready(out_ready), .instr(instr2), .addr(addr2), .err(err2), .err_count(err_count2)
    );

    typedef struct {
        logic [31:0] w;
        logic [31:0] a;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_addr;
    logic        m_err;
    int          m_cnt;
    int          tests = 0;
    int          fails = 0;

`ifdef INSTR_ENCODER_ERRCNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    // Returns {legal, word}, built from the mnemonic table.
    function automatic logic [32:0] ref_enc(input logic [3:0] m, input logic [4:0] s,
                                            input logic [4:0] t, input logic [4:0] d,
                                            input logic [15:0] im, input logic [25:0] tg);
        logic [5:0] op;
        logic [5:0] fn;
        case (m)
            0: op = 6'h23;  1: op = 6'h2B;  4: op = 6'h04;  5: op = 6'h05;
            6: op = 6'h0E;  7: op = 6'h08;  8: op = 6'h09;
            default: op = 6'h00;
        endcase
        case (m)
            9: fn = 6'h08;  10: fn = 6'h20;  11: fn = 6'h22;  12: fn = 6'h2A;
            default: fn = 6'h00;
        endcase
        if (m > 4'd12) return {1'b0, 32'h0};
        if (m == 4'd2) return {1'b1, 6'h02, tg};
        if (m == 4'd3) return {1'b1, 6'h03, tg};
        if (m == 4'd9) return {1'b1, 6'h00, s, 15'h0, fn};
        if (m >= 4'd10) return {1'b1, 6'h00, s, t, d, 5'h0, fn};
        return {1'b1, op, s, t, im};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_addr = 32'h0;
        m_err  = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    // Drive one cycle, check pre-edge outputs against the model, then advance the model.
    task automatic step(input logic v, input logic [3:0] m, input logic [4:0] s,
                        input logic [4:0] t, input logic [4:0] d, input logic [15:0] im,
                        input logic [25:0] tg, input logic ordy);
        logic [32:0] e;
        bit          acc, pp;
        in_valid = v; mnem = m; rs = s; rt = t; rd = d; imm = im; target = tg;
        out_ready = ordy;
        #1;
        chk("in_ready", {31'h0, in_ready}, {31'h0, q.size() < 2});
        chk("out_valid", {31'h0, out_valid}, {31'h0, q.size() > 0});
        if (q.size() > 0) begin
            chk("instr", instr, q[0].w);
            chk("addr", addr, q[0].a);
        end
        chk("err", {31'h0, err}, {31'h0, m_err});
        chk("err_count", {24'h0, err_count}, m_cnt);
        @(posedge clk);
        e   = ref_enc(m, s, t, d, im, tg);
        acc = v && (q.size() < 2);
        pp  = (q.size() > 0) && ordy;
        if (pp) void'(q.pop_front());
        if (acc && e[32]) begin
            q.push_back('{w: e[31:0], a: m_addr});
            m_addr = m_addr + 32'd4;
        end
        m_err = acc && !e[32];
        if (m_err && CntEn && m_cnt < 255) m_cnt++;
        @(negedge clk);
    endtask

    task automatic head(input string name, input logic [31:0] w, input logic [31:0] a);
        chk({name, "_valid"}, {31'h0, out_valid}, 32'h1);
        chk({name, "_instr"}, instr, w);
        chk({name, "_addr"}, addr, a);
    endtask

    logic [32:0] ea, eb, ec;

    initial begin
        in_valid = 0; mnem = 0; rs = 0; rt = 0; rd = 0; imm = 0; target = 0; out_ready = 0;
        reset = 1'b1;
        @(negedge clk);
        do_reset();
        #1;
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_err_count", {24'h0, err_count}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_addr", addr, 32'h0);
        @(negedge clk);

        step(1, 10, 1, 2, 3, 0, 0, 1);
        head("add", 32'h0022_1820, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 1);

        do_reset();
        step(1, 0, 29, 8, 0, 16'h0004, 0, 1);
        head("lw", 32'h8FA8_0004, 32'h0);
        step(1, 3, 0, 0, 0, 0, 26'h0000100, 1);
        head("jal", 32'h0C00_0100, 32'h4);
        step(0, 0, 0, 0, 0, 0, 0, 1);

        do_reset();
        step(1, 9, 31, 5, 7, 0, 0, 1);
        head("jr", 32'h03E0_0008, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 1);

        do_reset();
        ea = ref_enc(8, 1, 2, 0, 16'h0003, 0);
        eb = ref_enc(11, 4, 5, 6, 0, 0);
        ec = ref_enc(12, 7, 8, 9, 0, 0);
        step(1, 8, 1, 2, 0, 16'h0003, 0, 0);
        step(1, 11, 4, 5, 6, 0, 0, 0);
        chk("full_in_ready", {31'h0, in_ready}, 32'h0);
        step(1, 12, 7, 8, 9, 0, 0, 0);
        head("bp0", ea[31:0], 32'h0);
        chk("wrap_addr0", addr2, 32'hFFFF_FFF8);
        step(1, 12, 7, 8, 9, 0, 0, 1);
        head("bp1", eb[31:0], 32'h4);
        chk("wrap_addr1", addr2, 32'hFFFF_FFFC);
        chk("full_in_ready_after_pop", {31'h0, in_ready}, 32'h1);
        step(1, 12, 7, 8, 9, 0, 0, 1);
        head("bp2", ec[31:0], 32'h8);
        chk("wrap_addr2", addr2, 32'h0);
        chk("hi_instr", instr2, ec[31:0]);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("drained", {31'h0, out_valid}, 32'h0);

        do_reset();
        step(1, 14, 0, 0, 0, 0, 0, 1);
        chk("err_pulse", {31'h0, err}, 32'h1);
        chk("err_pulse_hi", {31'h0, err2}, 32'h1);
        chk("err_cnt_one", {24'h0, err_count}, CntEn ? 32'h1 : 32'h0);
        chk("err_cnt_one_hi", {24'h0, err_count2}, CntEn ? 32'h1 : 32'h0);
        chk("illegal_no_word", {31'h0, out_valid}, 32'h0);
        step(1, 7, 0, 4, 0, 16'hFFFF, 0, 1);
        chk("err_once", {31'h0, err}, 32'h0);
        head("addi", 32'h2004_FFFF, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 1);

        do_reset();
        step(1, 10, 1, 1, 1, 0, 0, 0);
        step(1, 11, 2, 2, 2, 0, 0, 0);
        do_reset();
        #1;
        chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
        @(negedge clk);
        step(1, 10, 1, 2, 3, 0, 0, 0);
        head("post_rst", 32'h0022_1820, 32'h0);

        do_reset();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 5'($urandom),
                 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom),
                 $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < 265; i++) begin
            step(1, 4'($urandom_range(13, 15)), 0, 0, 0, 0, 0, 1);
        end
        step(0, 0, 0, 0, 0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h00000000: byte address assigned to the first encoded word after reset.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: request carries a valid mnemonic and fields.
REQ-005 SHALL have port in_ready, output, 1 bit: encoder accepts the request this cycle.
REQ-006 SHALL have port mnem, input, 4 bits: 0 LW, 1 SW, 2 J, 3 JAL, 4 BEQ, 5 BNE, 6 XORI, 7 ADDI, 8 ADDIU, 9 JR, 10 ADD, 11 SUB, 12 SLT; 13-15 illegal.
REQ-007 SHALL have ports rs, rt, rd, input, 5 bits each: register fields.
REQ-008 SHALL have ports imm (input, 16 bits, I-type immediate) and target (input, 26 bits, J-type target).
REQ-009 SHALL have port out_valid, output, 1 bit: instr and addr hold an encoded word.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream consumes the word this cycle.
REQ-011 SHALL have ports instr (output, 32 bits, encoded word) and addr (output, 32 bits, byte address of instr).
REQ-012 SHALL have ports err (output, 1 bit, one-cycle illegal-mnemonic pulse) and err_count (output, 8 bits).

Function
REQ-013 SHALL accept a request when in_valid and in_ready are both high; SHALL pop a word when out_valid and out_ready are both high.
REQ-014 SHALL buffer encoded words in a 2-entry FIFO; in_ready = FIFO not full, computed from registered occupancy only (a same-cycle pop does not raise in_ready when full).
REQ-015 SHALL present an accepted legal word on out_valid no earlier than the cycle after acceptance; output order equals acceptance order.
REQ-016 I-type encoding {op,rs,rt,imm}, op: LW 100011, SW 101011, BEQ 000100, BNE 000101, XORI 001110, ADDI 001000, ADDIU 001001.
REQ-017 J-type encoding {op,target}, op: J 000010, JAL 000011.
REQ-018 R-type encoding {000000,rs,rt,rd,00000,funct}, funct: JR 001000, ADD 100000, SUB 100010, SLT 101010; JR forces rt and rd fields to zero.
REQ-019 SHALL tag each legal word with addr starting at BASE_ADDR and incrementing by 4 per accepted legal request; wraps 32'hFFFFFFFC -> 0.
REQ-020 Illegal mnemonic SHALL be accepted (if in_ready), not written to the FIFO, not advance addr, and pulse err high for exactly the following cycle.
REQ-021 Simultaneous accept and pop with FIFO at one entry SHALL keep occupancy at one and hold the new word.
REQ-022 instr and addr SHALL be held stable while out_valid is high and out_ready is low.

Reset
REQ-023 On reset: FIFO empty, out_valid 0, in_ready 1 the following cycle, err 0, err_count 0, next addr = BASE_ADDR, instr/addr outputs 0.
REQ-024 Reset asserted mid-operation SHALL discard all buffered words; no buffered word appears after reset deasserts.

Configuration
REQ-025 With macro INSTR_ENCODER_ERRCNT_EN defined, err_count SHALL increment on each illegal request, saturating at 8'hFF.
REQ-026 Without INSTR_ENCODER_ERRCNT_EN, err_count SHALL be driven constant 0 and no counter register exists; err pulse behaviour is unchanged.

Verification
REQ-027 ADD rs=1 rt=2 rd=3, out_ready=1 -> instr 32'h00221820, addr 0.
REQ-028 LW rs=29 rt=8 imm=16'h0004 then JAL target=26'h0000100 -> 32'h8FA80004 at addr 0, 32'h0C000100 at addr 4.
REQ-029 JR rs=31 rt=5 rd=7 -> 32'h03E00008 (rt/rd zeroed).
REQ-030 out_ready=0, three legal requests back-to-back -> in_ready low after second accept, third held; out_ready=1 -> three words at addr 0, 4, 8 in order.
REQ-031 mnem=14 then ADDI rs=0 rt=4 imm=16'hFFFF -> no word for mnem 14, err pulses once, err_count 1 (macro on) / 0 (off), ADDI 32'h2004FFFF at addr 0.
REQ-032 Two words buffered, out_ready=0, reset for one cycle -> out_valid 0 after reset, next legal word at addr BASE_ADDR.
